// File: rtl/nested_loop_addr_gen_pkg.sv
// Shared constants, FSM encoding and helpers for the nested-loop address generator.
package simd_loop_pkg;

  localparam logic [3:0] LOOP_CFG      = 4'b0111;
  localparam logic [3:0] FN_SET_BASE   = 4'b0000;
  localparam logic [3:0] FN_SET_ITER   = 4'b0001;
  localparam logic [3:0] FN_SET_STRIDE = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A programmed trip count of zero behaves as a single iteration.
  function automatic logic [31:0] eff_count(input logic [31:0] c);
    return (c == '0) ? 32'd1 : c;
  endfunction

endpackage

// File: rtl/nested_loop_addr_gen_if.sv
// Config instruction fields plus the valid/ready address stream of the generator.
interface nested_loop_addr_gen_if #(
  parameter int LEVEL_BITS    = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int IMM_WIDTH     = 32,
  parameter int OPCODE_BITS   = 4,
  parameter int FUNCTION_BITS = 4
);
  logic                     cfg_valid;
  logic [OPCODE_BITS-1:0]   opcode;
  logic [FUNCTION_BITS-1:0] fn;
  logic [LEVEL_BITS-1:0]    cfg_level;
  logic [IMM_WIDTH-1:0]     immediate;
  logic                     start;
  logic                     out_ready;
  logic                     out_valid;
  logic [ADDR_WIDTH-1:0]    address_out;
  logic                     out_last;
  logic                     busy;
  logic                     done;

  modport master (
    output cfg_valid, opcode, fn, cfg_level, immediate, start, out_ready,
    input  out_valid, address_out, out_last, busy, done
  );

  modport slave (
    input  cfg_valid, opcode, fn, cfg_level, immediate, start, out_ready,
    output out_valid, address_out, out_last, busy, done
  );
endinterface

// File: rtl/nested_loop_addr_gen_counter.sv
// Odometer of NUM_LEVELS iteration counters; level 0 is innermost.
module loop_counter_nest
  import simd_loop_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic [ITER_WIDTH-1:0] count [NUM_LEVELS],
  output logic [ITER_WIDTH-1:0] iter  [NUM_LEVELS],
  output logic                  all_last
);

  logic [NUM_LEVELS-1:0] wrap;
  logic [NUM_LEVELS-1:0] carry;
  logic                  chain;

  always_comb begin
    wrap  = '0;
    carry = '0;
    chain = advance;
    for (int unsigned l = 0; l < NUM_LEVELS; l++) begin
      wrap[l]  = (iter[l] == ITER_WIDTH'(eff_count(32'(count[l])) - 32'd1));
      carry[l] = chain;
      chain    = chain & wrap[l];
    end
  end

  assign all_last = &wrap;

  // Issuing the final tuple wraps every level, so the counters rest at zero between nests.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned l = 0; l < NUM_LEVELS; l++) iter[l] <= '0;
    end else begin
      for (int unsigned l = 0; l < NUM_LEVELS; l++) begin
        if (carry[l]) iter[l] <= wrap[l] ? '0 : iter[l] + ITER_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/nested_loop_addr_gen.sv
// Loop-nest address generator: config registers, run FSM and 2-stage address pipeline.
module nested_loop_addr_gen
  import simd_loop_pkg::*;
#(
  parameter int NUM_LEVELS    = 4,
  parameter int LEVEL_BITS    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  parameter int ADDR_WIDTH    = 32,
  parameter int STRIDE_WIDTH  = 32,
  parameter int ITER_WIDTH    = 16,
  parameter int IMM_WIDTH     = 32,
  parameter int OPCODE_BITS   = 4,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  nested_loop_addr_gen_if.slave  bus
);

  localparam int PW = STRIDE_WIDTH + ITER_WIDTH;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]          base;
  logic signed [STRIDE_WIDTH-1:0] stride [NUM_LEVELS];
  logic [ITER_WIDTH-1:0]          count  [NUM_LEVELS];
  logic [ITER_WIDTH-1:0]          iter   [NUM_LEVELS];
  logic [IMM_WIDTH-1:0]           imm;
  logic                           all_last, stall, issue, cfg_ok, accept_last;

  logic                  s1_valid, s1_last;
  logic signed [PW-1:0]  s1_prod [NUM_LEVELS];
  logic [ADDR_WIDTH-1:0] sum;
  logic                  out_valid, out_last;
  logic [ADDR_WIDTH-1:0] address;

  assign imm         = bus.immediate;
  assign stall       = out_valid & ~bus.out_ready;
  assign accept_last = out_valid & bus.out_ready & out_last;
  assign cfg_ok      = (state == ST_IDLE) && bus.cfg_valid &&
                       (bus.opcode == OPCODE_BITS'(LOOP_CFG));

  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
      for (int unsigned l = 0; l < NUM_LEVELS; l++) begin
        stride[l] <= '0;
        count[l]  <= '0;
      end
    end else if (cfg_ok) begin
      if (bus.fn == FUNCTION_BITS'(FN_SET_BASE)) base <= ADDR_WIDTH'(imm);
      for (int unsigned l = 0; l < NUM_LEVELS; l++) begin
        if (bus.cfg_level == LEVEL_BITS'(l)) begin
          if (bus.fn == FUNCTION_BITS'(FN_SET_ITER))   count[l]  <= ITER_WIDTH'(imm);
          if (bus.fn == FUNCTION_BITS'(FN_SET_STRIDE)) stride[l] <= STRIDE_WIDTH'($signed(imm));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Tuple 0 is issued on the start edge itself, saving a cycle of latency.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          issue      = 1'b1;
          state_next = all_last ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (all_last) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  loop_counter_nest #(
    .NUM_LEVELS (NUM_LEVELS),
    .ITER_WIDTH (ITER_WIDTH)
  ) u_counters (
    .clk      (clk),
    .reset    (reset),
    .advance  (issue),
    .count    (count),
    .iter     (iter),
    .all_last (all_last)
  );

  always_comb begin
    sum = base;
    for (int unsigned l = 0; l < NUM_LEVELS; l++) sum = sum + ADDR_WIDTH'(s1_prod[l]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      address   <= '0;
      for (int unsigned l = 0; l < NUM_LEVELS; l++) s1_prod[l] <= '0;
    end else if (!stall) begin
      s1_valid  <= issue;
      s1_last   <= issue & all_last;
      for (int unsigned l = 0; l < NUM_LEVELS; l++)
        s1_prod[l] <= $signed(PW'(stride[l])) * $signed(PW'(iter[l]));
      out_valid <= s1_valid;
      out_last  <= s1_last;
      address   <= sum;
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.address_out = address;
  assign bus.out_last    = out_last;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = (state == ST_DRAIN) & accept_last;

endmodule

// File: tb/tb_nested_loop_addr_gen.sv
// Self-checking bench: directed vector table, protection/reset sequences and random nests.
module tb_nested_loop_addr_gen;
  import simd_loop_pkg::*;

  localparam int NL = 4;
  localparam int LB = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nested_loop_addr_gen_if #(
    .LEVEL_BITS(LB), .ADDR_WIDTH(AW), .IMM_WIDTH(32), .OPCODE_BITS(4), .FUNCTION_BITS(4)
  ) bus ();

  nested_loop_addr_gen #(
    .NUM_LEVELS(NL), .LEVEL_BITS(LB), .ADDR_WIDTH(AW), .STRIDE_WIDTH(32),
    .ITER_WIDTH(16), .IMM_WIDTH(32), .OPCODE_BITS(4), .FUNCTION_BITS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string           name;
    logic [31:0]     base;
    logic [3:0][15:0] cnt;
    logic [3:0][31:0] str;
    int              mode;
    int              n;
    logic [5:0][31:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: enumerate the nest with plain div/mod arithmetic, iter[0] fastest.
  function automatic void build_expected(input logic [31:0] base, input logic [3:0][15:0] cnt,
                                         input logic [3:0][31:0] str);
    int unsigned c [4];
    int unsigned total, idx;
    logic [31:0] a;
    exp_q.delete();
    total = 1;
    for (int l = 0; l < 4; l++) begin
      c[l] = (cnt[l] == 16'd0) ? 1 : int'(cnt[l]);
      total = total * c[l];
    end
    for (int unsigned k = 0; k < total; k++) begin
      idx = k;
      a = base;
      for (int l = 0; l < 4; l++) begin
        a = a + str[l] * 32'(idx % c[l]);
        idx = idx / c[l];
      end
      exp_q.push_back(a);
    end
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return logic'(cyc % 2);
    return ($urandom_range(0, 9) < 7);
  endfunction

  task automatic cfg_write(input logic [3:0] op, input logic [3:0] f, input int lvl,
                           input logic [31:0] imm);
    bus.opcode    = op;
    bus.fn        = f;
    bus.cfg_level = LB'(lvl);
    bus.immediate = imm;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic program_nest(input logic [31:0] base, input logic [3:0][15:0] cnt,
                              input logic [3:0][31:0] str);
    cfg_write(LOOP_CFG, FN_SET_BASE, 0, base);
    for (int l = 0; l < 4; l++) begin
      cfg_write(LOOP_CFG, FN_SET_ITER, l, {16'd0, cnt[l]});
      cfg_write(LOOP_CFG, FN_SET_STRIDE, l, str[l]);
    end
  endtask

  // Launches a nest and checks every accepted address against exp_q.
  task automatic run_nest(input string name, input int mode, input bit inject);
    int bound;
    bit finished, prev_stall, accept, exp_done, exp_last;
    logic [31:0] prev_addr;
    logic prev_last;
    bound = exp_q.size() * 4 + 20;
    finished = 0;
    prev_stall = 0;
    prev_addr = '0;
    prev_last = 1'b0;
    bus.start = 1'b1;
    bus.out_ready = ready_for(mode, 0);
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc < bound && !finished; cyc++) begin
      if (inject && cyc == 3) begin
        bus.opcode = LOOP_CFG; bus.fn = FN_SET_STRIDE; bus.cfg_level = '0;
        bus.immediate = 32'h55; bus.cfg_valid = 1'b1; bus.start = 1'b1;
      end else begin
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
      end
      bus.out_ready = ready_for(mode, cyc);
      #1;
      if (cyc == 1) begin
        check({name, "_latency_c1"}, 32'(bus.out_valid), 0);
        check({name, "_busy"}, 32'(bus.busy), 1);
      end
      if (cyc == 2) check({name, "_latency_c2"}, 32'(bus.out_valid), 1);
      if (prev_stall) begin
        check({name, "_hold_valid"}, 32'(bus.out_valid), 1);
        check({name, "_hold_addr"}, bus.address_out, prev_addr);
        check({name, "_hold_last"}, 32'(bus.out_last), 32'(prev_last));
      end
      accept = bus.out_valid && bus.out_ready;
      exp_done = 0;
      if (accept) begin
        check({name, "_addr_expected"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check({name, "_addr"}, bus.address_out, exp_q.pop_front());
          exp_last = (exp_q.size() == 0);
          check({name, "_last"}, 32'(bus.out_last), 32'(exp_last));
          exp_done = exp_last;
        end
      end
      check({name, "_done"}, 32'(bus.done), 32'(exp_done));
      if (exp_done) finished = 1;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_addr  = bus.address_out;
      prev_last  = bus.out_last;
      tick();
    end
    bus.cfg_valid = 1'b0;
    bus.start = 1'b0;
    check({name, "_completed"}, 32'(finished), 1);
    check({name, "_leftover"}, 32'(exp_q.size()), 0);
    #1;
    check({name, "_idle_busy"}, 32'(bus.busy), 0);
    check({name, "_idle_valid"}, 32'(bus.out_valid), 0);
    check({name, "_idle_done"}, 32'(bus.done), 0);
    tick();
  endtask

  vec_t vecs [5];

  initial begin
    logic [3:0][15:0] rc;
    logic [3:0][31:0] rs;
    logic [31:0] rb;
    int drop_cnt, valid_cnt;

    vecs[0] = '{name: "single", base: 32'h1000, cnt: '0, str: '0, mode: 0, n: 3, exp: '0};
    vecs[0].cnt[0] = 16'd3; vecs[0].str[0] = 32'd4;
    vecs[0].exp[0] = 32'h1000; vecs[0].exp[1] = 32'h1004; vecs[0].exp[2] = 32'h1008;

    vecs[1] = '{name: "two_level", base: 32'h0, cnt: '0, str: '0, mode: 0, n: 6, exp: '0};
    vecs[1].cnt[0] = 16'd2; vecs[1].str[0] = 32'd1;
    vecs[1].cnt[1] = 16'd3; vecs[1].str[1] = 32'h100;
    vecs[1].exp[0] = 32'h000; vecs[1].exp[1] = 32'h001; vecs[1].exp[2] = 32'h100;
    vecs[1].exp[3] = 32'h101; vecs[1].exp[4] = 32'h200; vecs[1].exp[5] = 32'h201;

    vecs[2] = vecs[1];
    vecs[2].name = "backpressure";
    vecs[2].mode = 1;

    vecs[3] = '{name: "neg_stride", base: 32'h4, cnt: '0, str: '0, mode: 0, n: 3, exp: '0};
    vecs[3].cnt[0] = 16'd3; vecs[3].str[0] = 32'hFFFF_FFFC;
    vecs[3].exp[0] = 32'h4; vecs[3].exp[1] = 32'h0; vecs[3].exp[2] = 32'hFFFF_FFFC;

    vecs[4] = '{name: "zero_counts", base: 32'h20, cnt: '0, str: '0, mode: 0, n: 1, exp: '0};
    vecs[4].str[0] = 32'd7; vecs[4].str[2] = 32'd9;
    vecs[4].exp[0] = 32'h20;

    reset = 1'b1;
    bus.cfg_valid = 1'b0; bus.opcode = '0; bus.fn = '0; bus.cfg_level = '0;
    bus.immediate = '0; bus.start = 1'b0; bus.out_ready = 1'b1;
    tick(); tick();
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_last", 32'(bus.out_last), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_addr", bus.address_out, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      program_nest(vecs[v].base, vecs[v].cnt, vecs[v].str);
      exp_q.delete();
      for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].exp[j]);
      run_nest(vecs[v].name, vecs[v].mode, 1'b0);
    end

    // SET_STRIDE and start while busy must not disturb the nest or queue a second one.
    program_nest(vecs[1].base, vecs[1].cnt, vecs[1].str);
    build_expected(vecs[1].base, vecs[1].cnt, vecs[1].str);
    run_nest("protect", 0, 1'b1);
    build_expected(vecs[1].base, vecs[1].cnt, vecs[1].str);
    run_nest("protect_after", 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      rb = $urandom;
      for (int l = 0; l < 4; l++) begin
        rc[l] = 16'($urandom_range(0, 3));
        rs[l] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      end
      program_nest(rb, rc, rs);
      cfg_write(4'b0110, FN_SET_BASE, 0, $urandom);
      cfg_write(LOOP_CFG, 4'b0011, 1, $urandom);
      cfg_write(4'b0000, FN_SET_STRIDE, 0, $urandom);
      cfg_write(4'b1111, FN_SET_ITER, 2, $urandom);
      build_expected(rb, rc, rs);
      run_nest($sformatf("rand%0d", r), 2, 1'b0);
    end

    // Reset mid-nest aborts the stream and restores the cleared configuration.
    program_nest(vecs[1].base, vecs[1].cnt, vecs[1].str);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    #1;
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    reset = 1'b0;
    drop_cnt = 0;
    valid_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      if (bus.done) drop_cnt++;
      if (bus.out_valid) valid_cnt++;
    end
    check("midrst_no_done", 32'(drop_cnt), 0);
    check("midrst_no_valid", 32'(valid_cnt), 0);
    tick();
    build_expected(32'h0, '0, '0);
    run_nest("post_reset_cfg", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
